// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, BITS_PER_CYCLE bits per iteration, with a valid/ready response.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam int L  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [2*XLEN-1:0]   prod_q, prod_d, prod_step;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     mag_a, mag_b;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // prod holds {high, low} of the product, or {remainder, quotient} for divides.
    function automatic logic [XLEN-1:0] result_sel(input logic [2:0] op,
                                                   input logic [2*XLEN-1:0] p,
                                                   input logic n);
        logic [2*XLEN-1:0] prod;
        prod = neg2_if(p, n);
        case (op)
            OP_MUL:                       return prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              return neg_if(p[XLEN-1:0], n);
            default:                      return neg_if(p[2*XLEN-1:XLEN], n);
        endcase
    endfunction

    always_comb begin
        a_signed = req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = req_op inside {OP_MULH, OP_DIV, OP_REM};
        a_neg    = a_signed & req_a[XLEN-1];
        b_neg    = b_signed & req_b[XLEN-1];
        mag_a    = neg_if(req_a, a_neg);
        mag_b    = neg_if(req_b, b_neg);
        div_zero = req_op[2] && (req_b == '0);
        div_ovf  = req_op[2] && !req_op[0] && (req_b == '1) &&
                   (req_a == {1'b1, {(XLEN-1){1'b0}}});
    end

    always_comb begin
        logic [XLEN:0] part;
        prod_step = prod_q;
        part      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                part = {prod_step[2*XLEN-1:XLEN], prod_step[XLEN-1]};
                if (part >= {1'b0, mcand_q}) begin
                    part      = part - {1'b0, mcand_q};
                    prod_step = {part[XLEN-1:0], prod_step[XLEN-2:0], 1'b1};
                end else begin
                    prod_step = {part[XLEN-1:0], prod_step[XLEN-2:0], 1'b0};
                end
            end else begin
                part      = {1'b0, prod_step[2*XLEN-1:XLEN]} +
                            (prod_step[0] ? {1'b0, mcand_q} : '0);
                prod_step = {part, prod_step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    neg_d   = (req_op[2] & req_op[1]) ? a_neg : (a_neg ^ b_neg);
                    prod_d  = {{XLEN{1'b0}}, (req_op[2] ? mag_a : mag_b)};
                    mcand_d = req_op[2] ? mag_b : mag_a;
                    if (div_zero) begin
                        res_d   = req_op[1] ? req_a : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        res_d   = req_op[1] ? '0 : req_a;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = result_sel(op_q, prod_step, neg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // flush overrides acceptance, iteration and the response handshake alike
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_valid ? res_q : '0;
    assign resp_rd    = resp_valid ? rd_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors on a 1-bit/cycle and a
// 4-bit/cycle instance, plus flush, backpressure and reset scenarios.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid1 = 1'b0, req_valid4 = 1'b0;
    logic        flush = 1'b0, resp_ready = 1'b1;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [4:0]  req_rd = '0;

    logic        req_ready1, resp_valid1, busy1;
    logic [31:0] resp_data1;
    logic [4:0]  resp_rd1;
    logic        req_ready4, resp_valid4, busy4;
    logic [31:0] resp_data4;
    logic [4:0]  resp_rd4;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
        .resp_rd(resp_rd1), .busy(busy1)
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_data(resp_data4),
        .resp_rd(resp_rd4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] q1[$];
    logic [36:0] q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid1 && resp_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp1: got data 0x%0h rd %0d, expected no response", resp_data1, resp_rd1);
            end else begin
                logic [36:0] e;
                e = q1.pop_front();
                check("resp_data1", 64'(resp_data1), 64'(e[36:5]));
                check("resp_rd1", 64'(resp_rd1), 64'(e[4:0]));
            end
        end else if (!resp_valid1) begin
            check("data_zero1", 64'(resp_data1), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (resp_valid4 && resp_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp4: got data 0x%0h rd %0d, expected no response", resp_data4, resp_rd4);
            end else begin
                logic [36:0] e;
                e = q4.pop_front();
                check("resp_data4", 64'(resp_data4), 64'(e[36:5]));
                check("resp_rd4", 64'(resp_rd4), 64'(e[4:0]));
            end
        end
    end

    // Presents one request, then returns on the first negedge showing resp_valid.
    task automatic issue(input bit sel4, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat, input string name);
        int lat;
        bit got;
        @(posedge clk); #1;
        req_op = op; req_a = a; req_b = b; req_rd = rd;
        if (sel4) req_valid4 = 1'b1; else req_valid1 = 1'b1;
        @(negedge clk);
        check({name, "_req_ready"}, 64'(sel4 ? req_ready4 : req_ready1), 64'd1);
        if (sel4) q4.push_back({exp, rd}); else q1.push_back({exp, rd});
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        req_valid4 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = sel4 ? resp_valid4 : resp_valid1;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic run(input bit sel4, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat, input string name);
        issue(sel4, op, a, b, rd, exp, exp_lat, name);
        @(negedge clk);
        check({name, "_idle_after"}, 64'(sel4 ? req_ready4 : req_ready1), 64'd1);
    endtask

    initial begin
        logic [31:0] held_d;
        logic [4:0]  held_rd;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready1), 64'd1);
        check("rst_resp_valid", 64'(resp_valid1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_resp_data", 64'(resp_data1), 64'd0);
        check("rst_resp_rd", 64'(resp_rd1), 64'd0);

        // Request already present when reset releases: taken on the first edge.
        rst = 1'b1;
        req_op = MUL; req_a = 32'd3; req_b = 32'd5; req_rd = 5'd9; req_valid1 = 1'b1;
        q1.push_back({32'd15, 5'd9});
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        check("first_edge_accept_busy", 64'(busy1), 64'd1);
        repeat (40) @(negedge clk);

        run(0, MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, "mul");
        run(0, MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33, "mulh");
        run(0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, "mulhu");
        run(0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33, "mulhsu");
        run(0, DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33, "div_neg");
        run(0, REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33, "rem_neg");
        run(0, DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       33, "divu");
        run(0, REMU,   32'd100,      32'd7,        5'd13, 32'd2,        33, "remu");
        run(0, DIV,    32'd100,      32'hFFFFFFF9, 5'd14, 32'hFFFFFFF2, 33, "div_negdivisor");
        run(0, REM,    32'd100,      32'hFFFFFFF9, 5'd15, 32'd2,        33, "rem_negdivisor");
        run(0, DIVU,   32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1,  "divu_by_zero");
        run(0, REM,    32'd5,        32'd0,        5'd17, 32'd5,        1,  "rem_by_zero");
        run(0, DIV,    32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, 1,  "div_by_zero");
        run(0, DIV,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1,  "div_overflow");
        run(0, REM,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1,  "rem_overflow");

        // Flush in cycle T+10 of a divide.
        @(posedge clk); #1;
        req_op = DIV; req_a = 32'd1000; req_b = 32'd3; req_rd = 5'd21; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready1), 64'd1);
        check("flush_busy", 64'(busy1), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_no_resp", 64'(resp_valid1), 64'd0);

        // Flush coincident with a request drops it.
        @(posedge clk); #1;
        req_op = MUL; req_a = 32'd2; req_b = 32'd2; req_rd = 5'd22;
        req_valid1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_drop_busy", 64'(busy1), 64'd0);
        check("flush_drop_ready", 64'(req_ready1), 64'd1);
        repeat (40) @(negedge clk);

        // Consumer backpressure in DONE.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 32'hFFFFFFFE, 33, "hold");
        held_d = resp_data1;
        held_rd = resp_rd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 64'(resp_data1), 64'h00000000FFFFFFFE);
            check("hold_rd", 64'(resp_rd1), 64'd23);
            check("hold_busy", 64'(busy1), 64'd1);
            check("hold_valid", 64'(resp_valid1), 64'd1);
        end
        check("hold_data_stable", 64'(resp_data1), 64'(held_d));
        check("hold_rd_stable", 64'(resp_rd1), 64'(held_rd));
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_release_ready", 64'(req_ready1), 64'd1);
        check("hold_release_valid", 64'(resp_valid1), 64'd0);
        check("hold_release_busy", 64'(busy1), 64'd0);

        // Reset asserted mid-BUSY.
        @(posedge clk); #1;
        req_op = DIV; req_a = 32'd77; req_b = 32'd5; req_rd = 5'd24; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy1), 64'd0);
        check("midrst_ready", 64'(req_ready1), 64'd1);
        check("midrst_valid", 64'(resp_valid1), 64'd0);
        check("midrst_data", 64'(resp_data1), 64'd0);
        check("midrst_rd", 64'(resp_rd1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_resp", 64'(resp_valid1), 64'd0);

        run(1, MUL,    32'd7,        32'hFFFFFFFD, 5'd25, 32'hFFFFFFEB, 9, "mul_b4");
        run(1, MULH,   32'h80000000, 32'h80000000, 5'd26, 32'h40000000, 9, "mulh_b4");
        run(1, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd27, 32'hFFFFFFFE, 9, "mulhu_b4");
        run(1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd28, 32'hFFFFFFFF, 9, "mulhsu_b4");
        run(1, DIV,    32'hFFFFFFF9, 32'd2,        5'd29, 32'hFFFFFFFD, 9, "div_b4");

        repeat (3) @(negedge clk);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
